bbox_initiator: RTL and testbench
=================================

BBOX_INITIATOR -- requirements
Module: bbox_initiator

Interface
REQ-001 SHALL have parameter RID_WIDTH, default 8: request tag width.
REQ-002 SHALL have parameter MAX_OUT, default 8: maximum outstanding bbox requests (range 1..2^RID_WIDTH).
REQ-003 SHALL have parameter PAYLOAD_WIDTH, default 376: request payload width (15x8 quantized fields + 8x32 ray fields).
REQ-004 SHALL have port clk, input, 1: the single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port job_dat, input, PAYLOAD_WIDTH: node-test job payload.
REQ-007 SHALL have port job_vld, input, 1: job valid.
REQ-008 SHALL have port job_rdy, output, 1: job accepted when job_vld&job_rdy.
REQ-009 SHALL have port bbox_req_stream_rsc_dat, output, PAYLOAD_WIDTH+RID_WIDTH: {payload, rid}, rid in LSBs.
REQ-010 SHALL have ports bbox_req_stream_rsc_vld (output, 1) and bbox_req_stream_rsc_rdy (input, 1): request handshake.
REQ-011 SHALL have port bbox_resp_stream_rsc_dat, input, 195+RID_WIDTH: {hit[2:0], dist[191:0], rid}, rid in LSBs.
REQ-012 SHALL have ports bbox_resp_stream_rsc_vld (input, 1) and bbox_resp_stream_rsc_rdy (output, 1): response handshake.
REQ-013 SHALL have port res_dat, output, 197+RID_WIDTH: {hit_cnt[1:0], hit[2:0], dist[191:0], rid}.
REQ-014 SHALL have ports res_vld (output, 1) and res_rdy (input, 1): result handshake.
REQ-015 SHALL have port outstanding, output, clog2(MAX_OUT+1): issued-but-unanswered count.
REQ-016 SHALL have port rid_err, output, 1: sticky tag-order error flag.

Function
REQ-017 SHALL hold one request output register; job_rdy = ~rst & (~req_vld | req_rdy) & (outstanding + req_vld_pending < MAX_OUT), where req_vld_pending is 1 when req register holds an unsent request.
REQ-018 SHALL, on job accept, load req register with {job_dat, tx_rid} and assert bbox_req_stream_rsc_vld next cycle (latency 1).
REQ-019 SHALL hold req_dat/vld stable while vld&~rdy.
REQ-020 SHALL increment tx_rid by 1 per job accept, wrapping mod 2^RID_WIDTH.
REQ-021 SHALL increment outstanding on each req handshake and decrement on each resp handshake; both in same cycle leave it unchanged.
REQ-022 SHALL never let outstanding exceed MAX_OUT nor go below 0; a response handshake at outstanding==0 SHALL be accepted, counter held at 0, rid_err set.
REQ-023 SHALL keep expected rx_rid, incremented (wrapping) per response handshake; response rid != rx_rid SHALL set rid_err (sticky until reset), response still forwarded.
REQ-024 SHALL buffer results in a 2-entry FIFO; bbox_resp_stream_rsc_rdy = ~rst & FIFO not full (no combinational path from res_rdy).
REQ-025 SHALL compute hit_cnt = popcount(hit) saturated to 3 bits' max 3 (2 bits), dist and rid passed unchanged; result visible at res_vld the cycle after resp handshake.
REQ-026 SHALL deliver results in response arrival order; simultaneous push and pop on FIFO SHALL both occur, including when full (pop frees slot before push evaluated next cycle only; resp_rdy stays registered-full-based).
REQ-027 SHALL keep res_dat stable while res_vld&~res_rdy.

Reset
REQ-028 SHALL, while rst high at a rising edge, clear: req_vld, res_vld, FIFO, outstanding, tx_rid, rx_rid, rid_err to 0; job_rdy and bbox_resp_stream_rsc_rdy SHALL be 0 during rst.
REQ-029 SHALL discard any in-flight request/results on reset mid-operation; first post-reset job gets rid 0.

Verification
REQ-030 Single job, all ready high: job at cycle t -> req_vld at t+1 with rid 0; resp {hit=3'b101, rid 0} -> res_vld next cycle, hit_cnt=2, outstanding back to 0.
REQ-031 Credit limit: resp never returned, MAX_OUT=8 -> exactly 8 requests issued (rids 0..7), job_rdy low thereafter, outstanding=8; one resp -> exactly one more job accepted.
REQ-032 Backpressure: req_rdy low 5 cycles -> req_dat/vld constant, job_rdy low; res_rdy low -> after 2 results resp_rdy low, no result lost or reordered.
REQ-033 Tag wrap: 300 jobs with in-order responses -> rids 0..255,0..43, rid_err stays 0.
REQ-034 Out-of-order rid (expect 4, receive 5) -> rid_err=1 next cycle, held until rst; result still emitted with rid 5.
REQ-035 Reset with outstanding=3 and full FIFO -> all outputs 0 after one rst cycle; next job issued with rid 0.

Source files
------------

// File: rtl/bbox_initiator.sv
// Issues tagged bbox node-test requests under an outstanding-credit limit and
// returns responses, annotated with a hit count, through a 2-entry result FIFO.
module bbox_initiator #(
  parameter int RID_WIDTH     = 8,
  parameter int MAX_OUT       = 8,
  parameter int PAYLOAD_WIDTH = 376
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [PAYLOAD_WIDTH-1:0]           job_dat,
  input  logic                               job_vld,
  output logic                               job_rdy,
  output logic [PAYLOAD_WIDTH+RID_WIDTH-1:0] bbox_req_stream_rsc_dat,
  output logic                               bbox_req_stream_rsc_vld,
  input  logic                               bbox_req_stream_rsc_rdy,
  input  logic [195+RID_WIDTH-1:0]           bbox_resp_stream_rsc_dat,
  input  logic                               bbox_resp_stream_rsc_vld,
  output logic                               bbox_resp_stream_rsc_rdy,
  output logic [197+RID_WIDTH-1:0]           res_dat,
  output logic                               res_vld,
  input  logic                               res_rdy,
  output logic [$clog2(MAX_OUT+1)-1:0]       outstanding,
  output logic                               rid_err
);

  localparam int CNT_W = $clog2(MAX_OUT+1);
  localparam int RES_W = 197 + RID_WIDTH;

  logic [RID_WIDTH-1:0] tx_rid;
  logic [RID_WIDTH-1:0] rx_rid;
  logic [CNT_W:0]       in_flight;
  logic                 job_fire;
  logic                 req_fire;
  logic                 resp_fire;
  logic                 res_fire;

  logic [RID_WIDTH-1:0] resp_rid;
  logic [191:0]         resp_dist;
  logic [2:0]           resp_hit;
  logic [1:0]           resp_hit_cnt;

  logic [RES_W-1:0]     fifo_mem [2];
  logic                 fifo_wr_ptr;
  logic                 fifo_rd_ptr;
  logic [1:0]           fifo_cnt;

  // A request still sitting in the output register already holds a credit.
  assign in_flight = {1'b0, outstanding} + {{CNT_W{1'b0}}, bbox_req_stream_rsc_vld};
  assign job_rdy   = ~rst
                   & (~bbox_req_stream_rsc_vld | bbox_req_stream_rsc_rdy)
                   & (in_flight < (CNT_W+1)'(MAX_OUT));

  assign job_fire  = job_vld & job_rdy;
  assign req_fire  = bbox_req_stream_rsc_vld & bbox_req_stream_rsc_rdy;
  assign resp_fire = bbox_resp_stream_rsc_vld & bbox_resp_stream_rsc_rdy;
  assign res_fire  = res_vld & res_rdy;

  assign resp_rid     = bbox_resp_stream_rsc_dat[RID_WIDTH-1:0];
  assign resp_dist    = bbox_resp_stream_rsc_dat[RID_WIDTH+191:RID_WIDTH];
  assign resp_hit     = bbox_resp_stream_rsc_dat[RID_WIDTH+194:RID_WIDTH+192];
  assign resp_hit_cnt = {1'b0, resp_hit[0]} + {1'b0, resp_hit[1]} + {1'b0, resp_hit[2]};

  // Response readiness depends only on registered FIFO occupancy, never on res_rdy.
  assign bbox_resp_stream_rsc_rdy = ~rst & (fifo_cnt != 2'd2);
  assign res_vld = (fifo_cnt != 2'd0);
  assign res_dat = fifo_mem[fifo_rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      bbox_req_stream_rsc_vld <= 1'b0;
      bbox_req_stream_rsc_dat <= '0;
      tx_rid                  <= '0;
    end else if (job_fire) begin
      bbox_req_stream_rsc_vld <= 1'b1;
      bbox_req_stream_rsc_dat <= {job_dat, tx_rid};
      tx_rid                  <= tx_rid + RID_WIDTH'(1);
    end else if (req_fire) begin
      bbox_req_stream_rsc_vld <= 1'b0;
    end
  end

  // A response with nothing outstanding is still consumed but flagged as an error.
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
      rx_rid      <= '0;
      rid_err     <= 1'b0;
    end else begin
      if (req_fire && !resp_fire) begin
        outstanding <= outstanding + CNT_W'(1);
      end else if (resp_fire && !req_fire && outstanding != '0) begin
        outstanding <= outstanding - CNT_W'(1);
      end
      if (resp_fire) begin
        rx_rid <= rx_rid + RID_WIDTH'(1);
        if (resp_rid != rx_rid || outstanding == '0) begin
          rid_err <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      fifo_wr_ptr <= 1'b0;
      fifo_rd_ptr <= 1'b0;
      fifo_cnt    <= 2'd0;
    end else begin
      if (resp_fire) begin
        fifo_mem[fifo_wr_ptr] <= {resp_hit_cnt, resp_hit, resp_dist, resp_rid};
        fifo_wr_ptr           <= ~fifo_wr_ptr;
      end
      if (res_fire) begin
        fifo_rd_ptr <= ~fifo_rd_ptr;
      end
      case ({resp_fire, res_fire})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_bbox_initiator.sv
// Directed bench for bbox_initiator with a queue-based reference model checked
// every cycle, plus literal spot checks for each scenario.
module tb_bbox_initiator;

  localparam int MAX_OUT = 8;

  logic         clk;
  logic         rst;
  logic [375:0] job_dat;
  logic         job_vld;
  logic         job_rdy;
  logic [383:0] req_dat;
  logic         req_vld;
  logic         req_rdy;
  logic [202:0] resp_dat;
  logic         resp_vld;
  logic         resp_rdy;
  logic [204:0] res_dat;
  logic         res_vld;
  logic         res_rdy;
  logic [3:0]   outstanding;
  logic         rid_err;

  int total_cnt = 0;
  int bad_cnt   = 0;

  logic       job_acc;
  logic       resp_acc;
  logic [7:0] rsp_rid;

  bbox_initiator #(.RID_WIDTH(8), .MAX_OUT(MAX_OUT), .PAYLOAD_WIDTH(376)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .job_dat                  (job_dat),
    .job_vld                  (job_vld),
    .job_rdy                  (job_rdy),
    .bbox_req_stream_rsc_dat  (req_dat),
    .bbox_req_stream_rsc_vld  (req_vld),
    .bbox_req_stream_rsc_rdy  (req_rdy),
    .bbox_resp_stream_rsc_dat (resp_dat),
    .bbox_resp_stream_rsc_vld (resp_vld),
    .bbox_resp_stream_rsc_rdy (resp_rdy),
    .res_dat                  (res_dat),
    .res_vld                  (res_vld),
    .res_rdy                  (res_rdy),
    .outstanding              (outstanding),
    .rid_err                  (rid_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [383:0] act, input logic [383:0] exp);
    total_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [375:0] make_payload(input int k);
    logic [7:0] b;
    b = 8'(k * 37 + 5);
    return {47{b}};
  endfunction

  function automatic logic [202:0] make_resp(input logic [2:0] hit, input logic [7:0] seed,
                                             input logic [7:0] rid);
    return {hit, {24{seed}}, rid};
  endfunction

  // Reference model: queues of what must appear on the request and result ports.
  logic [383:0] req_q [$];
  logic [204:0] res_q [$];
  int           m_out;
  logic         m_err;
  logic [7:0]   m_tx;
  logic [7:0]   m_rx;
  bit           model_on = 0;
  logic         exp_job_rdy;
  logic         m_job_f, m_req_f, m_resp_f, m_res_f;
  logic [204:0] m_res;
  logic [2:0]   m_hit;
  int           m_pop;

  always @(negedge clk) begin
    exp_job_rdy = !rst && (req_q.size() == 0 || req_rdy) && (m_out + req_q.size() < MAX_OUT);
    if (model_on) begin
      checkOutput("job_rdy", job_rdy, exp_job_rdy);
      checkOutput("req_vld", req_vld, req_q.size() != 0);
      if (req_q.size() != 0) checkOutput("req_dat", req_dat, req_q[0]);
      checkOutput("outstanding", outstanding, m_out);
      checkOutput("rid_err", rid_err, m_err);
      checkOutput("resp_rdy", resp_rdy, !rst && res_q.size() < 2);
      checkOutput("res_vld", res_vld, res_q.size() != 0);
      if (res_q.size() != 0) checkOutput("res_dat", res_dat, res_q[0]);
    end
    if (rst) begin
      req_q.delete();
      res_q.delete();
      m_out    = 0;
      m_err    = 1'b0;
      m_tx     = 8'd0;
      m_rx     = 8'd0;
      model_on = 1;
    end else if (model_on) begin
      m_job_f  = job_vld && exp_job_rdy;
      m_req_f  = req_q.size() != 0 && req_rdy;
      m_resp_f = resp_vld && res_q.size() < 2;
      m_res_f  = res_q.size() != 0 && res_rdy;
      if (m_req_f) void'(req_q.pop_front());
      if (m_job_f) begin
        req_q.push_back({job_dat, m_tx});
        m_tx = m_tx + 8'd1;
      end
      if (m_resp_f) begin
        m_hit = resp_dat[202:200];
        m_pop = $countones(m_hit);
        if (m_pop > 3) m_pop = 3;
        m_res = {2'(m_pop), m_hit, resp_dat[199:8], resp_dat[7:0]};
        if (resp_dat[7:0] != m_rx || m_out == 0) m_err = 1'b1;
        m_rx = m_rx + 8'd1;
      end
      if (m_res_f) void'(res_q.pop_front());
      if (m_resp_f) res_q.push_back(m_res);
      if (m_req_f && !m_resp_f) m_out++;
      else if (m_resp_f && !m_req_f && m_out > 0) m_out--;
    end
  end

  task automatic applyStimulus(input logic jv, input logic [375:0] jd, input logic qr,
                               input logic rv, input logic [202:0] rd, input logic sr);
    job_vld  = jv;
    job_dat  = jd;
    req_rdy  = qr;
    resp_vld = rv;
    resp_dat = rd;
    res_rdy  = sr;
    #1;
    job_acc  = jv && job_rdy;
    resp_acc = rv && resp_rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst      = 1'b1;
    job_vld  = 1'b0;
    job_dat  = '0;
    resp_vld = 1'b0;
    resp_dat = '0;
    req_rdy  = 1'b1;
    res_rdy  = 1'b1;
    rsp_rid  = 8'd0;
    #1;
    checkOutput("job_rdy_in_rst", job_rdy, 0);
    checkOutput("resp_rdy_in_rst", resp_rdy, 0);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    checkOutput("rst_req_vld", req_vld, 0);
    checkOutput("rst_res_vld", res_vld, 0);
    checkOutput("rst_outstanding", outstanding, 0);
    checkOutput("rst_rid_err", rid_err, 0);
  endtask

  task automatic send_resps(input int n);
    int sent = 0;
    for (int c = 0; c < 50 && sent < n; c++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b1, make_resp(rsp_rid[2:0], rsp_rid + 8'h40, rsp_rid), 1'b1);
      if (resp_acc) begin
        rsp_rid = rsp_rid + 8'd1;
        sent++;
      end
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
    checkOutput("send_resps_done", sent, n);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: run exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc;
    int got;
    rst = 1'b1;
    do_reset(2);

    // Single job round trip
    applyStimulus(1'b1, make_payload(1), 1'b1, 1'b0, '0, 1'b1);
    checkOutput("single_job_acc", job_acc, 1);
    checkOutput("single_req_vld", req_vld, 1);
    checkOutput("single_req_dat", req_dat, {make_payload(1), 8'h00});
    applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
    checkOutput("single_outstanding", outstanding, 1);
    applyStimulus(1'b0, '0, 1'b1, 1'b1, make_resp(3'b101, 8'h11, 8'h00), 1'b1);
    checkOutput("single_res_vld", res_vld, 1);
    checkOutput("single_hit_cnt", res_dat[204:203], 2);
    checkOutput("single_res_dat", res_dat, {2'd2, 3'b101, {24{8'h11}}, 8'h00});
    checkOutput("single_out_zero", outstanding, 0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
    checkOutput("single_res_gone", res_vld, 0);

    // Credit limit with no responses
    do_reset(1);
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, make_payload(i + 10), 1'b1, 1'b0, '0, 1'b1);
      if (job_acc) acc++;
    end
    checkOutput("credit_accepts", acc, 8);
    checkOutput("credit_outstanding", outstanding, 8);
    checkOutput("credit_job_rdy", job_rdy, 0);
    applyStimulus(1'b1, make_payload(40), 1'b1, 1'b1, make_resp(3'b110, 8'h21, 8'h00), 1'b1);
    checkOutput("credit_resp_acc", resp_acc, 1);
    checkOutput("credit_hit_cnt", res_dat[204:203], 2);
    rsp_rid = 8'd1;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, make_payload(i + 41), 1'b1, 1'b0, '0, 1'b1);
      if (job_acc) acc++;
    end
    checkOutput("credit_one_more", acc, 1);
    checkOutput("credit_out_full", outstanding, 8);
    send_resps(8);
    checkOutput("credit_drained", outstanding, 0);

    // Request and result backpressure
    do_reset(1);
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, make_payload(50 + i), 1'b0, 1'b0, '0, 1'b1);
      if (job_acc) acc++;
      checkOutput("bp_req_hold", req_dat, {make_payload(50), 8'h00});
    end
    checkOutput("bp_accepts", acc, 1);
    checkOutput("bp_job_rdy", job_rdy, 0);
    checkOutput("bp_req_vld", req_vld, 1);
    for (int i = 0; i < 4; i++) applyStimulus(i < 2, make_payload(60 + i), 1'b1, 1'b0, '0, 1'b1);
    checkOutput("bp_outstanding", outstanding, 3);
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b1, make_resp(rsp_rid[2:0], rsp_rid + 8'h40, rsp_rid), 1'b0);
      if (resp_acc) begin
        rsp_rid = rsp_rid + 8'd1;
        acc++;
      end
    end
    checkOutput("bp_resp_accepts", acc, 2);
    checkOutput("bp_resp_rdy_low", resp_rdy, 0);
    checkOutput("bp_head_rid", res_dat[7:0], 0);
    send_resps(1);
    repeat (3) applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
    checkOutput("bp_drained", res_vld, 0);
    checkOutput("bp_out_zero", outstanding, 0);

    // Tag wrap over 300 jobs with in-order responses
    do_reset(1);
    acc = 0;
    got = 0;
    for (int c = 0; c < 2000 && got < 300; c++) begin
      applyStimulus(acc < 300, make_payload(acc), 1'b1, outstanding != 4'd0,
                    make_resp(rsp_rid[2:0], rsp_rid, rsp_rid), 1'b1);
      if (job_acc) begin
        acc++;
        if (acc == 257) checkOutput("wrap_rid_zero", req_dat[7:0], 0);
        if (acc == 300) checkOutput("wrap_last_rid", req_dat[7:0], 43);
      end
      if (resp_acc) begin
        rsp_rid = rsp_rid + 8'd1;
        got++;
      end
    end
    checkOutput("wrap_jobs", acc, 300);
    checkOutput("wrap_resps", got, 300);
    checkOutput("wrap_rid_err", rid_err, 0);

    // Out-of-order tag
    do_reset(1);
    for (int i = 0; i < 8; i++) applyStimulus(i < 6, make_payload(100 + i), 1'b1, 1'b0, '0, 1'b1);
    checkOutput("ooo_outstanding", outstanding, 6);
    send_resps(4);
    checkOutput("ooo_no_err_yet", rid_err, 0);
    applyStimulus(1'b0, '0, 1'b1, 1'b1, make_resp(3'b011, 8'h55, 8'd5), 1'b1);
    checkOutput("ooo_resp_acc", resp_acc, 1);
    checkOutput("ooo_rid_err", rid_err, 1);
    checkOutput("ooo_res_vld", res_vld, 1);
    checkOutput("ooo_res_rid", res_dat[7:0], 5);
    applyStimulus(1'b0, '0, 1'b1, 1'b1, make_resp(3'b111, 8'h66, 8'd4), 1'b1);
    checkOutput("ooo_hit_cnt3", res_dat[204:203], 3);
    repeat (3) applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
    checkOutput("ooo_err_sticky", rid_err, 1);
    checkOutput("ooo_out_zero", outstanding, 0);

    // Reset with work in flight
    do_reset(1);
    for (int i = 0; i < 6; i++) applyStimulus(i < 5, make_payload(200 + i), 1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, make_payload(210), 1'b0, 1'b1, make_resp(3'b111, 8'h77, rsp_rid + 8'd1), 1'b0);
      if (resp_acc) rsp_rid = rsp_rid + 8'd1;
    end
    checkOutput("mid_outstanding", outstanding, 3);
    checkOutput("mid_fifo_full", resp_rdy, 0);
    checkOutput("mid_req_pending", req_vld, 1);
    checkOutput("mid_rid_err", rid_err, 1);
    do_reset(1);
    applyStimulus(1'b1, make_payload(222), 1'b0, 1'b0, '0, 1'b1);
    checkOutput("post_rst_req_vld", req_vld, 1);
    checkOutput("post_rst_req_dat", req_dat, {make_payload(222), 8'h00});
    applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
    send_resps(1);
    checkOutput("post_rst_clean", rid_err, 0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
